// File: rtl/cache_mem_arbiter_pkg.sv
// cache_arb_pkg: shared types and block geometry for the cache/memory arbiter.
package cache_arb_pkg;
    localparam int BLK_WORDS  = 8;
    localparam int WORD_IDX_W = $clog2(BLK_WORDS);
    localparam int MEM_LAT    = 4;
    typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: request, memory and fill signals between both caches, memory and the arbiter.
interface cache_mem_arbiter_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
    import cache_arb_pkg::*;
    logic              i_miss_req;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss_req;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              i_fill_we;
    logic              d_fill_we;
    logic [WORD_IDX_W-1:0] fill_word;
    logic [DATA_W-1:0] fill_data;
    logic              i_fill_done;
    logic              d_fill_done;
    logic              d_wr_done;
    modport master (
        input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
               mem_data_out, mem_data_valid,
        output mem_en, mem_wr, mem_addr, mem_data_in, i_fill_we, d_fill_we, fill_word, fill_data,
               i_fill_done, d_fill_done, d_wr_done
    );
    modport slave (
        output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
               mem_data_out, mem_data_valid,
        input  mem_en, mem_wr, mem_addr, mem_data_in, i_fill_we, d_fill_we, fill_word, fill_data,
               i_fill_done, d_fill_done, d_wr_done
    );
endinterface

// File: rtl/arb_word_seq.sv
// arb_word_seq: issue/return word counters of a block fill, offset by the start word with wrap.
module arb_word_seq import cache_arb_pkg::*; (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  issue_en,
    input  logic                  ret_en,
    input  logic [WORD_IDX_W-1:0] start,
    output logic [WORD_IDX_W-1:0] issue_idx,
    output logic [WORD_IDX_W-1:0] ret_idx,
    output logic                  issue_last,
    output logic                  return_last
);
    logic [WORD_IDX_W-1:0] ic, rc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic <= '0;
            rc <= '0;
        end else if (clr) begin
            ic <= '0;
            rc <= '0;
        end else begin
            if (issue_en) ic <= ic + 1'b1;
            if (ret_en) rc <= rc + 1'b1;
        end
    end
    // Sum truncates to the index width, giving the mod-BLK_WORDS wrap for free.
    assign issue_idx   = start + ic;
    assign ret_idx     = start + rc;
    assign issue_last  = ic == WORD_IDX_W'(BLK_WORDS - 1);
    assign return_last = rc == WORD_IDX_W'(BLK_WORDS - 1);
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares main memory between I/D miss fills and D write-through stores.
// Define CACHE_ARB_CWF_EN for critical-word-first fills; otherwise fills start at word 0.
module cache_mem_arbiter import cache_arb_pkg::*; #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input logic clk,
    input logic rst_n,
    cache_mem_arbiter_if.master bus
);
    localparam int BASE_W = ADDR_W - WORD_IDX_W - 1;
    state_t state, state_nxt;
    owner_t owner;
    logic [BASE_W-1:0] base;
    logic [WORD_IDX_W-1:0] start, issue_idx, ret_idx;
    logic issued, issue_last, return_last, grant_miss;
    assign grant_miss = state == IDLE && !bus.d_wr_req && (bus.d_miss_req || bus.i_miss_req);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= OWN_I;
            base   <= '0;
            issued <= 1'b0;
        end else begin
            state  <= state_nxt;
            issued <= state == FILL && (issued || issue_last);
            if (grant_miss) begin
                owner <= bus.d_miss_req ? OWN_D : OWN_I;
                base  <= bus.d_miss_req ? bus.d_miss_addr[ADDR_W-1:WORD_IDX_W+1]
                                        : bus.i_miss_addr[ADDR_W-1:WORD_IDX_W+1];
            end
        end
    end
`ifdef CACHE_ARB_CWF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) start <= '0;
        else if (grant_miss)
            start <= bus.d_miss_req ? bus.d_miss_addr[WORD_IDX_W:1] : bus.i_miss_addr[WORD_IDX_W:1];
    end
`else
    assign start = '0;
`endif
    arb_word_seq u_seq (
        .clk(clk), .rst_n(rst_n), .clr(state != FILL), .issue_en(state == FILL && !issued),
        .ret_en(state == FILL && bus.mem_data_valid), .start(start),
        .issue_idx(issue_idx), .ret_idx(ret_idx), .issue_last(issue_last), .return_last(return_last)
    );
    always_comb begin
        state_nxt       = state;
        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_data_in = '0;
        bus.i_fill_we   = 1'b0;
        bus.d_fill_we   = 1'b0;
        bus.fill_word   = '0;
        bus.fill_data   = '0;
        bus.i_fill_done = 1'b0;
        bus.d_fill_done = 1'b0;
        bus.d_wr_done   = 1'b0;
        unique case (state)
            IDLE: state_nxt = bus.d_wr_req ? WRITE : grant_miss ? FILL : IDLE;
            WRITE: begin
                bus.mem_en      = 1'b1;
                bus.mem_wr      = 1'b1;
                bus.mem_addr    = bus.d_wr_addr;
                bus.mem_data_in = bus.d_wr_data;
                bus.d_wr_done   = 1'b1;
                state_nxt       = IDLE;
            end
            FILL: begin
                bus.mem_en   = !issued;
                bus.mem_addr = issued ? '0 : {base, issue_idx, 1'b0};
                if (bus.mem_data_valid) begin
                    bus.fill_word   = ret_idx;
                    bus.fill_data   = bus.mem_data_out;
                    bus.i_fill_we   = owner == OWN_I;
                    bus.d_fill_we   = owner == OWN_D;
                    bus.i_fill_done = return_last && owner == OWN_I;
                    bus.d_fill_done = return_last && owner == OWN_D;
                    state_nxt       = return_last ? IDLE : FILL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: table-driven and random request mixes against a 4-cycle pipelined memory model.
module tb_cache_mem_arbiter;
`ifdef CACHE_ARB_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    typedef struct {
        bit wr, dm, im;
        logic [15:0] wa, wd, da, ia;
        logic [15:0] exp_addr0;
        int exp_word0;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;
    cache_mem_arbiter_if bus();
    cache_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nchk = 0, npass = 0;

    // Memory: each read issue returns addr^5A5A four cycles later, in order.
    logic [3:0]  pv = '0;
    logic [15:0] pd [4];
    logic        extra_v = 1'b0;
    logic [15:0] extra_d = '0;
    always @(posedge clk) begin
        pv <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
        pd[0] <= bus.mem_addr ^ 16'h5A5A;
        for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
    end
    assign bus.mem_data_valid = pv[3] | extra_v;
    assign bus.mem_data_out   = pv[3] ? pd[3] : extra_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int word_idx(input logic [15:0] a, input int r);
        int st;
        st = CWF ? int'(a[3:1]) : 0;
        return (st + r) % 8;
    endfunction

    function automatic logic [15:0] word_addr(input logic [15:0] a, input int r);
        return (a & 16'hFFF0) + 16'(word_idx(a, r) * 2);
    endfunction

    task automatic chk_quiet(input string name);
        chk(name, {bus.mem_en, bus.i_fill_we, bus.d_fill_we, bus.i_fill_done, bus.d_fill_done,
                   bus.d_wr_done, bus.fill_word}, '0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.i_fill_we, bus.d_fill_we,
                   bus.fill_word, bus.fill_data, bus.i_fill_done, bus.d_fill_done, bus.d_wr_done}, '0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, output logic [15:0] a0);
        @(negedge clk);
        a0 = bus.mem_addr;
        chk("wr_en_wr", {bus.mem_en, bus.mem_wr}, 2'b11);
        chk("wr_addr", bus.mem_addr, a);
        chk("wr_data", bus.mem_data_in, d);
        chk("wr_done", {bus.d_wr_done, bus.d_fill_done, bus.i_fill_done}, 3'b100);
        @(negedge clk);
        bus.d_wr_req = 1'b0;
        chk("wr_after", bus.mem_en, 1'b0);
    endtask

    task automatic do_fill(input bit own_d, input logic [15:0] a, output logic [15:0] a0, output int w0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) a0 = bus.mem_addr;
            if (k == 5) w0 = int'(bus.fill_word);
            if (k <= 8) begin
                chk("fill_issue", {bus.mem_en, bus.mem_wr}, 2'b10);
                chk("fill_addr", bus.mem_addr, word_addr(a, k - 1));
            end else chk("fill_issue_end", bus.mem_en, 1'b0);
            if (k >= 5) begin
                chk("fill_we", {bus.i_fill_we, bus.d_fill_we}, own_d ? 2'b01 : 2'b10);
                chk("fill_word", bus.fill_word, word_idx(a, k - 5));
                chk("fill_data", bus.fill_data, word_addr(a, k - 5) ^ 16'h5A5A);
            end else chk("fill_we_early", {bus.i_fill_we, bus.d_fill_we}, 2'b00);
            chk("fill_done", {bus.i_fill_done, bus.d_fill_done, bus.d_wr_done},
                k == 12 ? (own_d ? 3'b010 : 3'b100) : 3'b000);
        end
        @(negedge clk);
        if (own_d) bus.d_miss_req = 1'b0;
        else bus.i_miss_req = 1'b0;
        chk("fill_after", bus.mem_en, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] a0;
        int w0;
        bit first;
        first = 1'b1;
        bus.d_wr_req = v.wr;  bus.d_wr_addr = v.wa;  bus.d_wr_data = v.wd;
        bus.d_miss_req = v.dm; bus.d_miss_addr = v.da;
        bus.i_miss_req = v.im; bus.i_miss_addr = v.ia;
        if (v.wr) begin
            do_write(v.wa, v.wd, a0);
            chk("first_addr", a0, v.exp_addr0);
            first = 1'b0;
        end
        if (v.dm) begin
            do_fill(1'b1, v.da, a0, w0);
            if (first) begin
                chk("first_addr", a0, v.exp_addr0);
                chk("first_word", w0, v.exp_word0);
            end
            first = 1'b0;
        end
        if (v.im) begin
            do_fill(1'b0, v.ia, a0, w0);
            if (first) begin
                chk("first_addr", a0, v.exp_addr0);
                chk("first_word", w0, v.exp_word0);
            end
        end
    endtask

    initial begin
        vec_t tbl [6];
        vec_t v;
        logic [2:0] m;
        tbl[0] = '{0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h0124, CWF ? 16'h0124 : 16'h0120, CWF ? 2 : 0};
        tbl[1] = '{1, 0, 0, 16'h4000, 16'hBEEF, 16'h0, 16'h0, 16'h4000, 0};
        tbl[2] = '{1, 1, 1, 16'h1000, 16'h1234, 16'h2346, 16'h0124, 16'h1000, 0};
        tbl[3] = '{0, 1, 0, 16'h0, 16'h0, 16'hFFFE, 16'h0, CWF ? 16'hFFFE : 16'hFFF0, CWF ? 7 : 0};
        tbl[4] = '{0, 1, 1, 16'h0, 16'h0, 16'h0008, 16'h3002, CWF ? 16'h0008 : 16'h0000, CWF ? 4 : 0};
        tbl[5] = '{1, 1, 0, 16'h0002, 16'h00FF, 16'h7770, 16'h0, 16'h0002, 0};
        {bus.i_miss_req, bus.d_miss_req, bus.d_wr_req} = '0;
        {bus.i_miss_addr, bus.d_miss_addr, bus.d_wr_addr, bus.d_wr_data} = '0;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Stray returns while idle must be ignored and leave the counters at zero.
        extra_v = 1'b1;
        extra_d = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            chk_quiet("idle_valid");
            chk("idle_fill_data", bus.fill_data, 16'h0);
        end
        extra_v = 1'b0;
        foreach (tbl[i]) run_vec(tbl[i]);
        // Reset in the sixth fill cycle aborts; late memory returns must not reach a cache.
        bus.i_miss_req = 1'b1;
        bus.i_miss_addr = 16'h0124;
        repeat (5) @(negedge clk);
        chk("pre_abort_en", bus.mem_en, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("abort_outputs");
        @(negedge clk);
        bus.i_miss_req = 1'b0;
        chk_all_zero("abort_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            extra_v = (k == 5);
            @(negedge clk);
            chk_quiet("post_abort");
        end
        extra_v = 1'b0;
        run_vec(tbl[0]);
        for (int n = 0; n < 10; n++) begin
            m = 3'($urandom_range(1, 7));
            v.wr = m[2]; v.dm = m[1]; v.im = m[0];
            v.wa = 16'($urandom); v.wd = 16'($urandom);
            v.da = 16'($urandom); v.ia = 16'($urandom);
            v.exp_addr0 = v.wr ? v.wa : word_addr(v.dm ? v.da : v.ia, 0);
            v.exp_word0 = word_idx(v.dm ? v.da : v.ia, 0);
            run_vec(v);
        end
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single-ported, 4-cycle pipelined main memory between the I-cache and D-cache miss handlers of the five-stage CPU. It grants one requester at a time, sequences the 8-word block fill for a granted miss, steers returning words into the requesting cache's data array, and issues single-word write-through stores from the D-cache. It sits inside the cache/memory wrapper, between both cache controllers and the main memory instance.

## Interface
- `ADDR_W`, 16: byte address width.
- `DATA_W`, 16: word width.
- `BLK_WORDS`, 8: words per cache block; a power of two.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_miss_req` in 1: I-cache miss pending. Level signal, held until `i_fill_done`.
- `i_miss_addr` in ADDR_W: byte address of the I-cache miss.
- `d_miss_req` in 1: D-cache read miss pending. Level signal, held until `d_fill_done`.
- `d_miss_addr` in ADDR_W: byte address of the D-cache miss.
- `d_wr_req` in 1: write-through store pending. Level signal, held until `d_wr_done`.
- `d_wr_addr` in ADDR_W: store address.
- `d_wr_data` in DATA_W: store data.
- `mem_data_out` in DATA_W: memory read data.
- `mem_data_valid` in 1: `mem_data_out` is valid this cycle.
- `mem_en` out 1: memory access this cycle.
- `mem_wr` out 1: the access is a write.
- `mem_addr` out ADDR_W: memory byte address.
- `mem_data_in` out DATA_W: memory write data.
- `i_fill_we`, `d_fill_we` out 1: write `fill_data` into the selected cache at `fill_word`.
- `fill_word` out log2(BLK_WORDS): word index within the block.
- `fill_data` out DATA_W: returned word; equals `mem_data_out`.
- `i_fill_done`, `d_fill_done`, `d_wr_done` out 1: single-cycle completion pulses.

## Operation
- FSM states: IDLE, WRITE, FILL. A 1-bit owner register holds I or D while in FILL.
- IDLE arbitration uses fixed priority, sampled at each posedge: `d_wr_req` > `d_miss_req` > `i_miss_req`.
  - Store granted: go to WRITE.
  - Miss granted: go to FILL. Latch the owner, the block base `addr[15:4]`, and the start word `addr[3:1]`.
- WRITE lasts exactly one cycle:
  - `mem_en=1`, `mem_wr=1`, `mem_addr=d_wr_addr`, `mem_data_in=d_wr_data`, `d_wr_done=1`.
  - Then return to IDLE.
- FILL issue phase:
  - Issue counter `ic` runs 0..BLK_WORDS-1 over BLK_WORDS consecutive cycles.
  - Each cycle: `mem_en=1`, `mem_wr=0`, `mem_addr={base, (start+ic) mod BLK_WORDS, 1'b0}`.
  - After the last issue, `mem_en=0`.
- FILL return phase:
  - Return counter `rc` increments on each `mem_data_valid`.
  - Each valid return: assert the owner's `*_fill_we` with `fill_word=(start+rc) mod BLK_WORDS`.
  - The return that brings `rc` to BLK_WORDS also asserts the owner's `*_fill_done` in the same cycle. Next state is IDLE.
- `mem_data_valid` outside FILL is ignored: no fill strobes, no counter change.
- Address arithmetic for the word index wraps mod BLK_WORDS. The block base is never incremented.
- Requesters drop `req` in the cycle after their done pulse. The arbiter may re-grant a request that is still high in IDLE.
- Requests arriving while not in IDLE wait; nothing is queued internally.

## Timing
- All outputs are 0 at reset. State=IDLE, counters=0.
- Reset asserted mid-FILL or mid-WRITE aborts immediately. No done pulse is produced, and in-flight memory returns after release are ignored because the FSM is in IDLE.
- Grant latency: request high at edge N puts the first `mem_en` in cycle N+1.
- Store: `d_wr_done` in cycle N+1; next grant at edge N+2.
- Fill, with memory latency 4: issues in cycles N+1..N+8, returns in N+5..N+12, done in N+12. Total 12 cycles from grant edge to done.
- Done pulses are exactly one cycle wide. At most one of the three done pulses is high per cycle.
- Simultaneous `d_wr_req` and `d_miss_req`: the store goes first, and the miss is granted at the edge after `d_wr_done`.

## Configuration
- `CACHE_ARB_CWF_EN` defined: critical-word-first. `start=addr[3:1]`, so the missing word returns first and the index wraps.
- Not defined: `start` is forced to 0. Fills always run word 0..7 in order; `addr[3:1]` is ignored.

## Structure
- Shared package `cache_arb_pkg`:
  - state enum (IDLE/WRITE/FILL) and owner enum (I/D);
  - `BLK_WORDS`, `WORD_IDX_W`, `MEM_LAT=4`.
- One sub-module, `arb_word_seq`: holds the issue and return counters plus the start-offset wrap add. It outputs issue index, return index, `issue_last` and `return_last`.

## Test plan
- Reset, then I-miss at 0x0124 (CWF on): `mem_addr` sequence 0x0124, 0x0126, 0x0128, 0x012A, 0x012C, 0x012E, 0x0120, 0x0122. `fill_word` sequence 2,3,4,5,6,7,0,1. `i_fill_done` 12 cycles after grant.
- Same miss with CWF off: `mem_addr` 0x0120..0x012E ascending, `fill_word` 0..7.
- `d_wr_req`, `d_miss_req` and `i_miss_req` all high in one cycle: order is store (`d_wr_done` at +1), then D fill (done +12), then I fill. `i_fill_we` is never high during the D fill.
- Store 0xBEEF to 0x4000: a single cycle with `mem_en=1`, `mem_wr=1`, `mem_addr=0x4000`, `mem_data_in=0xBEEF`, and `d_wr_done=1`.
- `rst_n` low during the 6th cycle of a fill: all outputs are 0 immediately. After release, stray `mem_data_valid` pulses produce no `fill_we` and no done.
- `mem_data_valid` pulsed in IDLE: no output change, and the counters stay 0.
